ycbcr422_decoder: RTL and testbench

Receive-side counterpart of the framebuffer's YCbCr 4:2:2 output stage: accepts the 16-bit multiplexed 4:2:2 video stream with h/v sync and data-enable and reconstructs a 4:4:4 pixel stream, one pixel per clock. It also tracks pixel coordinates, measures the active frame geometry and flags malformed lines. It sits in the HDMI loopback/capture path and feeds frame checkers and capture buffers.

---
 rtl/ycbcr422_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_ycbcr422_decoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr422_decoder.sv
// ycbcr422_decoder
//   Rebuilds a 4:4:4 pixel stream from a 16-bit multiplexed YCbCr 4:2:2 stream.
//   It tracks pixel coordinates, measures the active line width and frame height,
//   and flags lines that end on an odd pixel count. Latency is a fixed 2 cycles.
//
// Ports
//   i_clk, i_rst              pixel clock, synchronous active-high reset
//   i_hsync/i_vsync/i_de      input syncs and data enable
//   i_ycbcr[15:8] = Y, [7:0] = Cb (even pixel) / Cr (odd pixel)
//   o_hsync/o_vsync/o_de      input syncs delayed by 2 cycles
//   o_valid                   pixel/coordinate outputs valid
//   o_y8/o_cb/o_cr            reconstructed 4:4:4 pixel
//   o_x/o_y                   pixel column / line index
//   o_locked                  a vsync rising edge has been seen since reset
//   o_width/o_height          last completed line width / frame height
//   o_err_odd                 one-cycle pulse: line ended on an odd pixel count
module ycbcr422_decoder #(
    parameter int unsigned XBITS = 12,
    parameter int unsigned YBITS = 12
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_de,
    input  logic [15:0]      i_ycbcr,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_de,
    output logic             o_valid,
    output logic [7:0]       o_y8,
    output logic [7:0]       o_cb,
    output logic [7:0]       o_cr,
    output logic [XBITS-1:0] o_x,
    output logic [YBITS-1:0] o_y,
    output logic             o_locked,
    output logic [XBITS-1:0] o_width,
    output logic [YBITS-1:0] o_height,
    output logic             o_err_odd
);

    typedef enum logic {StEven, StOdd} state_e;

    state_e state_q, state_d;

    // Sync pipeline: stage 1, stage 2 (outputs), plus previous o_vsync for edge detect.
    logic hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q, vs3_q;

    logic [7:0] y0_q, y0_d, cb_q, cb_d, y1_q, y1_d, cr_q, cr_d;
    logic       pend1_q, pend1_d, err_pend_q, err_pend_d;

    logic             valid_q, valid_d, vprev_q;
    logic [7:0]       pix_y_q, pix_y_d, pix_cb_q, pix_cb_d, pix_cr_q, pix_cr_d;
    logic [XBITS-1:0] x_q, x_d, width_q, width_d;
    logic [YBITS-1:0] y_q, y_d, height_q, height_d;
    logic             locked_q, locked_d, err_q;

    logic vs_rise_in, cap_even, emit_pair, emit_short;
    logic raw_valid, vs_rise_out, valid_fall;

    // Rising edge of i_vsync; vs1_q is i_vsync one cycle ago.
    assign vs_rise_in = i_vsync & ~vs1_q;

    // ---------------- pairing FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StEven;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (vs_rise_in) begin
            state_d = StEven;  // drop any half pair at frame start
        end else begin
            case (state_q)
                StEven:  if (i_de) state_d = StOdd;
                StOdd:   state_d = StEven;
                default: state_d = StEven;
            endcase
        end
    end

    always_comb begin
        cap_even   = 1'b0;
        emit_pair  = 1'b0;
        emit_short = 1'b0;
        if (!vs_rise_in) begin
            case (state_q)
                StEven: cap_even = i_de;
                StOdd: begin
                    emit_pair  = i_de;
                    emit_short = ~i_de;
                end
                default: ;
            endcase
        end
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        y0_d       = y0_q;
        cb_d       = cb_q;
        y1_d       = y1_q;
        cr_d       = cr_q;
        if (cap_even) begin
            y0_d = i_ycbcr[15:8];
            cb_d = i_ycbcr[7:0];
        end
        if (emit_pair) begin
            y1_d = i_ycbcr[15:8];
            cr_d = i_ycbcr[7:0];
        end
        pend1_d    = emit_pair;
        err_pend_d = emit_short;

        // pixel0 leaves on the odd-pixel cycle using the live Cr; pixel1 follows from registers.
        raw_valid = emit_pair | emit_short | pend1_q;
        if (pend1_q) begin
            pix_y_d  = y1_q;
            pix_cb_d = cb_q;
            pix_cr_d = cr_q;
        end else begin
            pix_y_d  = y0_q;
            pix_cb_d = cb_q;
            pix_cr_d = emit_pair ? i_ycbcr[7:0] : 8'h80;
        end

        // Edge events seen on the output-timed signals take effect one cycle later.
        vs_rise_out = vs2_q & ~vs3_q;
        valid_fall  = ~valid_q & vprev_q;

        locked_d = locked_q | vs_rise_out;
        valid_d  = raw_valid & locked_d;

        width_d = width_q;
        if (valid_fall) begin
            width_d = (x_q == '1) ? x_q : x_q + XBITS'(1);
        end

        x_d = x_q;
        if (valid_d) begin
            if (!valid_q)      x_d = '0;
            else if (x_q != '1) x_d = x_q + XBITS'(1);
        end

        height_d = height_q;
        y_d      = y_q;
        if (vs_rise_out) begin
            if (locked_q) height_d = y_q;
            y_d = '0;
        end else if (valid_fall && (y_q != '1)) begin
            y_d = y_q + YBITS'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            de1_q      <= 1'b0;
            hs2_q      <= 1'b0;
            vs2_q      <= 1'b0;
            de2_q      <= 1'b0;
            vs3_q      <= 1'b0;
            y0_q       <= '0;
            cb_q       <= '0;
            y1_q       <= '0;
            cr_q       <= '0;
            pend1_q    <= 1'b0;
            err_pend_q <= 1'b0;
            valid_q    <= 1'b0;
            vprev_q    <= 1'b0;
            pix_y_q    <= '0;
            pix_cb_q   <= '0;
            pix_cr_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            width_q    <= '0;
            height_q   <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            hs1_q      <= i_hsync;
            vs1_q      <= i_vsync;
            de1_q      <= i_de;
            hs2_q      <= hs1_q;
            vs2_q      <= vs1_q;
            de2_q      <= de1_q;
            vs3_q      <= vs2_q;
            y0_q       <= y0_d;
            cb_q       <= cb_d;
            y1_q       <= y1_d;
            cr_q       <= cr_d;
            pend1_q    <= pend1_d;
            err_pend_q <= err_pend_d;
            valid_q    <= valid_d;
            vprev_q    <= valid_q;
            if (valid_d) begin
                pix_y_q  <= pix_y_d;
                pix_cb_q <= pix_cb_d;
                pix_cr_q <= pix_cr_d;
            end
            x_q        <= x_d;
            y_q        <= y_d;
            width_q    <= width_d;
            height_q   <= height_d;
            locked_q   <= locked_d;
            err_q      <= err_pend_q;
        end
    end

    assign o_hsync   = hs2_q;
    assign o_vsync   = vs2_q;
    assign o_de      = de2_q;
    assign o_valid   = valid_q;
    assign o_y8      = pix_y_q;
    assign o_cb      = pix_cb_q;
    assign o_cr      = pix_cr_q;
    assign o_x       = x_q;
    assign o_y       = y_q;
    assign o_locked  = locked_q;
    assign o_width   = width_q;
    assign o_height  = height_q;
    assign o_err_odd = err_q;

endmodule

// File: tb/tb_ycbcr422_decoder.sv
// Testbench for ycbcr422_decoder: randomized and directed stimulus checked every
// cycle against a behavioural model, plus literal expectations for directed lines.
module tb_ycbcr422_decoder;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_hsync = 1'b0, i_vsync = 1'b0, i_de = 1'b0;
    logic [15:0] i_ycbcr = 16'h0;
    logic        o_hsync, o_vsync, o_de, o_valid, o_locked, o_err_odd;
    logic [7:0]  o_y8, o_cb, o_cr;
    logic [11:0] o_x, o_y, o_width, o_height;

    always #5 clk = ~clk;

    ycbcr422_decoder #(.XBITS(12), .YBITS(12)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de),
        .i_ycbcr(i_ycbcr), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
        .o_valid(o_valid), .o_y8(o_y8), .o_cb(o_cb), .o_cr(o_cr), .o_x(o_x), .o_y(o_y),
        .o_locked(o_locked), .o_width(o_width), .o_height(o_height), .o_err_odd(o_err_odd)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] sat12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    // ---------------- behavioural model ----------------
    // Expected outputs are kept in ring slots indexed by the clock edge after which
    // they become visible: a pair completed at edge p shows pixel0 at p, pixel1 at p+1.
    logic       m_pv[64], m_perr[64], m_hs[64], m_vs[64], m_de[64];
    logic [7:0] m_py[64], m_pcb[64], m_pcr[64];
    logic       have_even, in_vs_prev, ovs1, ovs2, ov1, ov2, m_locked;
    logic [7:0] ey, ecb;
    logic [11:0] m_x, m_y, m_w, m_h;
    logic       e_hs, e_vs, e_de, e_valid, e_err;
    logic [7:0] e_y8, e_cb, e_cr;
    int unsigned cyc = 0;
    bit         started = 0;

    initial begin : model
        int unsigned s, sn;
        logic rise, fall, orise, cv;
        forever begin
            @(posedge clk);
            cyc++;
            s  = cyc % 64;
            sn = (cyc + 1) % 64;
            started = 1;
            if (i_rst) begin
                for (int i = 0; i < 64; i++) begin
                    m_pv[i] = 0; m_perr[i] = 0; m_hs[i] = 0; m_vs[i] = 0; m_de[i] = 0;
                end
                have_even = 0; in_vs_prev = 0;
                ovs1 = 0; ovs2 = 0; ov1 = 0; ov2 = 0;
                m_locked = 0; m_x = 0; m_y = 0; m_w = 0; m_h = 0;
                e_hs = 0; e_vs = 0; e_de = 0; e_valid = 0; e_err = 0;
                e_y8 = 0; e_cb = 0; e_cr = 0;
            end else begin
                m_hs[sn] = i_hsync; m_vs[sn] = i_vsync; m_de[sn] = i_de;
                rise = i_vsync && !in_vs_prev;
                in_vs_prev = i_vsync;
                if (rise) begin
                    have_even = 0;
                end else if (i_de) begin
                    if (!have_even) begin
                        have_even = 1; ey = i_ycbcr[15:8]; ecb = i_ycbcr[7:0];
                    end else begin
                        m_pv[s] = 1; m_py[s] = ey; m_pcb[s] = ecb; m_pcr[s] = i_ycbcr[7:0];
                        m_pv[sn] = 1; m_py[sn] = i_ycbcr[15:8];
                        m_pcb[sn] = ecb; m_pcr[sn] = i_ycbcr[7:0];
                        have_even = 0;
                    end
                end else if (have_even) begin
                    m_pv[s] = 1; m_py[s] = ey; m_pcb[s] = ecb; m_pcr[s] = 8'h80;
                    m_perr[sn] = 1;
                    have_even = 0;
                end
                // Frame bookkeeping: edges on the visible outputs act one cycle later.
                orise = ovs1 && !ovs2;
                fall  = !ov1 && ov2;
                if (fall) m_w = sat12(m_x);
                if (orise) begin
                    if (m_locked) m_h = m_y;
                    m_y = 0;
                    m_locked = 1;
                end else if (fall) begin
                    m_y = sat12(m_y);
                end
                cv = m_pv[s] && m_locked;
                if (cv) m_x = ov1 ? sat12(m_x) : 12'd0;
                e_hs = m_hs[s]; e_vs = m_vs[s]; e_de = m_de[s];
                e_valid = cv; e_err = m_perr[s];
                e_y8 = m_py[s]; e_cb = m_pcb[s]; e_cr = m_pcr[s];
                ovs2 = ovs1; ovs1 = m_vs[s]; ov2 = ov1; ov1 = cv;
                m_pv[s] = 0; m_perr[s] = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    typedef struct {
        logic [7:0]  y8, cb, cr;
        logic [11:0] x, y;
    } pix_t;
    pix_t cap[$];
    int   err_cnt = 0;
    int   valid_cnt = 0;

    initial begin : compare
        pix_t p;
        forever begin
            @(negedge clk);
            if (started) begin
                check("hsync",  32'(o_hsync),   32'(e_hs));
                check("vsync",  32'(o_vsync),   32'(e_vs));
                check("de",     32'(o_de),      32'(e_de));
                check("valid",  32'(o_valid),   32'(e_valid));
                check("err",    32'(o_err_odd), 32'(e_err));
                check("locked", 32'(o_locked),  32'(m_locked));
                check("width",  32'(o_width),   32'(m_w));
                check("height", 32'(o_height),  32'(m_h));
                if (e_valid) begin
                    check("y8", 32'(o_y8), 32'(e_y8));
                    check("cb", 32'(o_cb), 32'(e_cb));
                    check("cr", 32'(o_cr), 32'(e_cr));
                    check("x",  32'(o_x),  32'(m_x));
                    check("y",  32'(o_y),  32'(m_y));
                end
                if (o_valid) begin
                    p.y8 = o_y8; p.cb = o_cb; p.cr = o_cr; p.x = o_x; p.y = o_y;
                    cap.push_back(p);
                    valid_cnt++;
                end
                if (o_err_odd) err_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rst, input logic hs, input logic vs, input logic de,
                         input logic [15:0] d);
        @(negedge clk);
        i_rst = rst; i_hsync = hs; i_vsync = vs; i_de = de; i_ycbcr = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic vsync_pulse();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
        idle(3);
    endtask

    task automatic line(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, {8'(i + 8'h21), 8'(i * 5)});
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        idle(2);
    endtask

    task automatic check_pix(input int i, input logic [7:0] y8, input logic [7:0] cb,
                             input logic [7:0] cr, input logic [11:0] x, input logic [11:0] yy);
        if (i >= cap.size()) begin
            n_tests++;
            n_fail++;
            $display("FAIL pix%0d: missing, only %0d captured", i, cap.size());
        end else begin
            check($sformatf("pix%0d_y8", i), 32'(cap[i].y8), 32'(y8));
            check($sformatf("pix%0d_cb", i), 32'(cap[i].cb), 32'(cb));
            check($sformatf("pix%0d_cr", i), 32'(cap[i].cr), 32'(cr));
            check($sformatf("pix%0d_x", i),  32'(cap[i].x),  32'(x));
            check($sformatf("pix%0d_y", i),  32'(cap[i].y),  32'(yy));
        end
    endtask

    initial begin : stim
        // Reset with random inputs.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("rst_locked", 32'(o_locked), 32'd0);
        check("rst_valid",  32'(o_valid),  32'd0);
        check("rst_hsync",  32'(o_hsync),  32'd0);
        check("rst_vsync",  32'(o_vsync),  32'd0);
        check("rst_width",  32'(o_width),  32'd0);
        check("rst_height", 32'(o_height), 32'd0);

        // No vsync yet: pixels must stay invalid.
        valid_cnt = 0;
        for (int i = 0; i < 20; i++)
            drive(1'b0, 1'($urandom), 1'b0, 1'($urandom), 16'($urandom));
        idle(3);
        check("nolock_valid_cnt", 32'(valid_cnt), 32'd0);

        // Single even line.
        vsync_pulse();
        idle(2);
        cap.delete();
        err_cnt = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1020);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1130);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1240);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h1350);
        idle(6);
        check("line4_count", 32'(cap.size()), 32'd4);
        check_pix(0, 8'h10, 8'h20, 8'h30, 12'd0, 12'd0);
        check_pix(1, 8'h11, 8'h20, 8'h30, 12'd1, 12'd0);
        check_pix(2, 8'h12, 8'h40, 8'h50, 12'd2, 12'd0);
        check_pix(3, 8'h13, 8'h40, 8'h50, 12'd3, 12'd0);
        check("line4_width", 32'(o_width), 32'd4);
        check("line4_err",   32'(err_cnt), 32'd0);

        // Odd-terminated line.
        cap.delete();
        err_cnt = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hA001);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hA102);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'hA203);
        idle(6);
        check("line3_count", 32'(cap.size()), 32'd3);
        check_pix(0, 8'hA0, 8'h01, 8'h02, 12'd0, 12'd1);
        check_pix(1, 8'hA1, 8'h01, 8'h02, 12'd1, 12'd1);
        check_pix(2, 8'hA2, 8'h03, 8'h80, 12'd2, 12'd1);
        check("line3_err",   32'(err_cnt), 32'd1);
        check("line3_width", 32'(o_width), 32'd3);

        // Two frames of 1080 lines, then wide lines for width and x saturation.
        vsync_pulse();
        err_cnt = 0;
        for (int l = 0; l < 1080; l++) line(8);
        vsync_pulse();
        check("frame1_height", 32'(o_height), 32'd1080);
        check("frame1_y_wrap", 32'(o_y),      32'd0);
        check("frame1_width",  32'(o_width),  32'd8);
        for (int l = 0; l < 1080; l++) line(8);
        vsync_pulse();
        check("frame2_height", 32'(o_height), 32'd1080);
        check("frame_err",     32'(err_cnt),  32'd0);
        line(1920);
        idle(2);
        check("width_1920", 32'(o_width), 32'd1920);
        line(4100);
        idle(2);
        check("width_sat", 32'(o_width), 32'hFFF);

        // Random sync / data toggles.
        for (int i = 0; i < 400; i++)
            drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        idle(4);

        // Reset in the middle of a line, then a clean line after a new vsync.
        vsync_pulse();
        idle(2);
        for (int i = 0; i < 16; i++) begin
            drive((i == 7), 1'b0, 1'b0, 1'b1, {8'(8'h40 + i), 8'(i * 3)});
            if (i == 8) begin
                check("midrst_valid",  32'(o_valid),  32'd0);
                check("midrst_locked", 32'(o_locked), 32'd0);
                check("midrst_de",     32'(o_de),     32'd0);
                check("midrst_x",      32'(o_x),      32'd0);
                check("midrst_width",  32'(o_width),  32'd0);
            end
        end
        idle(4);
        vsync_pulse();
        idle(2);
        cap.delete();
        for (int i = 0; i < 16; i++)
            drive(1'b0, 1'b0, 1'b0, 1'b1, {8'(8'h40 + i), 8'(i * 3)});
        idle(6);
        check("post_rst_count", 32'(cap.size()), 32'd16);
        check_pix(0,  8'h40, 8'h00, 8'h03, 12'd0,  12'd0);
        check_pix(15, 8'h4F, 8'h2A, 8'h2D, 12'd15, 12'd0);
        check("post_rst_width", 32'(o_width), 32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
